// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through cache.
package cache_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 13;
    localparam int DEF_LINES  = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOOKUP     = 2'd1,
        MISS_READ  = 2'd2,
        WRITE_THRU = 2'd3
    } state_t;

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays: one registered write port, single-cycle flush, combinational lookup.
import cache_pkg::*;

module cache_line_store #(
    parameter int LINES  = DEF_LINES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = $clog2(LINES),
    parameter int TAG_W  = ADDR_W - IDX_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [TAG_W-1:0]  i_rd_tag,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Valid bits: cleared together by reset or flush, set by a fill/update.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_valid <= {LINES{1'b0}};
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload; validity alone decides whether a line is usable.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_hit     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_data = r_data[i_rd_idx];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache presenting Main_Memory's
// request/Done handshake to the CPU and driving Main_Memory on the far side.
import cache_pkg::*;

module cache_controller #(
    parameter int LINES  = DEF_LINES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              read,
    input  logic              write,
    input  logic              instruction,
    input  logic              flush,
    output logic [DATA_W-1:0] dataOut,
    output logic              Done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_instruction,
    input  logic              mem_Done,
    output logic [7:0]        hit_count,
    output logic [7:0]        miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_instr;
    logic              r_is_write;
    logic [DATA_W-1:0] r_dout;
    logic              r_done;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [7:0]        r_hit_cnt;
    logic [7:0]        r_miss_cnt;

    logic              w_latch;
    logic              w_flush;
    logic              w_store_wr;
    logic [DATA_W-1:0] w_store_data;
    logic              w_done_nxt;
    logic              w_dout_ld;
    logic [DATA_W-1:0] w_dout_nxt;
    logic              w_mem_read_nxt;
    logic              w_mem_write_nxt;
    logic              w_hit_inc;
    logic              w_miss_inc;
    logic              w_hit;
    logic [DATA_W-1:0] w_line_data;

    cache_line_store #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_store (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_flush   (w_flush),
        .i_wr_en   (w_store_wr),
        .i_wr_idx  (r_addr[IDX_W-1:0]),
        .i_wr_tag  (r_addr[ADDR_W-1:IDX_W]),
        .i_wr_data (w_store_data),
        .i_rd_idx  (r_addr[IDX_W-1:0]),
        .i_rd_tag  (r_addr[ADDR_W-1:IDX_W]),
        .o_hit     (w_hit),
        .o_rd_data (w_line_data)
    );

    // Next-state and per-cycle actions of the request FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_latch         = 1'b0;
        w_flush         = 1'b0;
        w_store_wr      = 1'b0;
        w_store_data    = r_wdata;
        w_done_nxt      = 1'b0;
        w_dout_ld       = 1'b0;
        w_dout_nxt      = r_dout;
        w_mem_read_nxt  = r_mem_read;
        w_mem_write_nxt = r_mem_write;
        w_hit_inc       = 1'b0;
        w_miss_inc      = 1'b0;
        case (r_state)
            IDLE: begin
                // r_done blocks the still-held request from being retaken.
                if (flush) begin
                    w_flush = 1'b1;
                end else if (!r_done && (read || write)) begin
                    w_latch     = 1'b1;
                    w_state_nxt = LOOKUP;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOOKUP: begin
                if (r_is_write) begin
                    if (w_hit) begin
                        w_store_wr = 1'b1;
                    end else begin
                        w_store_wr = 1'b0;
                    end
                    w_mem_write_nxt = 1'b1;
                    w_state_nxt     = WRITE_THRU;
                end else if (w_hit) begin
                    w_done_nxt  = 1'b1;
                    w_dout_ld   = 1'b1;
                    w_dout_nxt  = w_line_data;
                    w_hit_inc   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_miss_inc     = 1'b1;
                    w_mem_read_nxt = 1'b1;
                    w_state_nxt    = MISS_READ;
                end
            end
            MISS_READ: begin
                if (mem_Done) begin
                    w_store_wr     = 1'b1;
                    w_store_data   = mem_dataOut;
                    w_done_nxt     = 1'b1;
                    w_dout_ld      = 1'b1;
                    w_dout_nxt     = mem_dataOut;
                    w_mem_read_nxt = 1'b0;
                    w_state_nxt    = IDLE;
                end else begin
                    w_state_nxt = MISS_READ;
                end
            end
            WRITE_THRU: begin
                if (mem_Done) begin
                    w_done_nxt      = 1'b1;
                    w_mem_write_nxt = 1'b0;
                    w_state_nxt     = IDLE;
                end else begin
                    w_state_nxt = WRITE_THRU;
                end
            end
            default: begin
                w_mem_read_nxt  = 1'b0;
                w_mem_write_nxt = 1'b0;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    // State, request latches, registered outputs and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= {ADDR_W{1'b0}};
            r_wdata     <= {DATA_W{1'b0}};
            r_instr     <= 1'b0;
            r_is_write  <= 1'b0;
            r_dout      <= {DATA_W{1'b0}};
            r_done      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_hit_cnt   <= 8'h00;
            r_miss_cnt  <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= w_done_nxt;
            r_mem_read  <= w_mem_read_nxt;
            r_mem_write <= w_mem_write_nxt;
            if (w_latch) begin
                r_addr     <= address;
                r_wdata    <= dataIn;
                r_instr    <= instruction;
                r_is_write <= write;
            end
            if (w_dout_ld) begin
                r_dout <= w_dout_nxt;
            end
            if (w_hit_inc && (r_hit_cnt != 8'hFF)) begin
                r_hit_cnt <= r_hit_cnt + 8'd1;
            end
            if (w_miss_inc && (r_miss_cnt != 8'hFF)) begin
                r_miss_cnt <= r_miss_cnt + 8'd1;
            end
        end
    end

    assign dataOut         = r_dout;
    assign Done            = r_done;
    assign mem_address     = r_addr;
    assign mem_dataIn      = r_wdata;
    assign mem_instruction = r_instr;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign hit_count       = r_hit_cnt;
    assign miss_count      = r_miss_cnt;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a two-cycle-latency memory responder.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] address;
    logic [12:0] dataIn;
    logic        read;
    logic        write;
    logic        instruction;
    logic        flush;
    logic [12:0] dataOut;
    logic        Done;
    logic [12:0] mem_address;
    logic [12:0] mem_dataIn;
    logic [12:0] mem_dataOut;
    logic        mem_read;
    logic        mem_write;
    logic        mem_instruction;
    logic        mem_Done;
    logic [7:0]  hit_count;
    logic [7:0]  miss_count;

    int errors = 0;
    int checks = 0;

    int          lat;
    int          rd_cyc;
    int          wr_cyc;
    int          both;
    logic [12:0] maddr;
    logic [12:0] mdin;
    logic        minstr;
    logic        mem_at_done;
    logic [12:0] dout_at_done;
    logic        done_after;

    cache_controller dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .dataIn          (dataIn),
        .read            (read),
        .write           (write),
        .instruction     (instruction),
        .flush           (flush),
        .dataOut         (dataOut),
        .Done            (Done),
        .mem_address     (mem_address),
        .mem_dataIn      (mem_dataIn),
        .mem_dataOut     (mem_dataOut),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_instruction (mem_instruction),
        .mem_Done        (mem_Done),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Holds one CPU request until Done; memory answers two cycles after its request rises.
    task automatic run_req(input logic [12:0] a, input logic [12:0] d, input logic rd,
                           input logic wr, input logic ins, input logic [12:0] mdat);
        int pend;
        pend = 0; lat = 0; rd_cyc = 0; wr_cyc = 0; both = 0;
        maddr = 13'h0; mdin = 13'h0; minstr = 1'b0; mem_at_done = 1'b0;
        address = a; dataIn = d; read = rd; write = wr; instruction = ins;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (mem_Done) mem_Done = 1'b0;
            if (Done) begin
                lat = n;
                mem_at_done = mem_read | mem_write;
                break;
            end
            if (mem_read) rd_cyc++;
            if (mem_write) wr_cyc++;
            if (mem_read && mem_write) both++;
            if (mem_read || mem_write) begin
                maddr = mem_address; mdin = mem_dataIn; minstr = mem_instruction;
                pend++;
                if (pend == 2) begin
                    mem_Done = 1'b1;
                    mem_dataOut = mdat;
                end
            end
        end
        read = 1'b0; write = 1'b0; instruction = 1'b0;
        dout_at_done = dataOut;
        tick();
        done_after = Done;
    endtask

    initial begin
        reset = 1'b1; address = 13'h0; dataIn = 13'h0; read = 1'b0; write = 1'b0;
        instruction = 1'b0; flush = 1'b0; mem_dataOut = 13'h0; mem_Done = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_done", Done, 1'b0);
        chk("rst_dout", dataOut, 13'h0);
        chk("rst_memrw", {mem_read, mem_write}, 2'b00);
        chk("rst_maddr", mem_address, 13'h0);
        chk("rst_cnt", {hit_count, miss_count}, 16'h0000);

        // Stray mem_Done while idle
        mem_Done = 1'b1; tick(); mem_Done = 1'b0; tick();
        chk("idle_memdone", {Done, mem_read, mem_write}, 3'b000);

        // Cold read miss
        run_req(13'h005, 13'h0, 1'b1, 1'b0, 1'b0, 13'h10F0);
        chk("cold_lat", lat, 4);
        chk("cold_rdcyc", rd_cyc, 2);
        chk("cold_wrcyc", wr_cyc, 0);
        chk("cold_maddr", maddr, 13'h005);
        chk("cold_memfall", mem_at_done, 1'b0);
        chk("cold_dout", dout_at_done, 13'h10F0);
        chk("cold_pulse", done_after, 1'b0);
        chk("cold_held", dataOut, 13'h10F0);
        chk("cold_cnt", {hit_count, miss_count}, 16'h0001);

        // Read hit
        run_req(13'h005, 13'h0, 1'b1, 1'b0, 1'b0, 13'h1FFF);
        chk("hit_lat", lat, 2);
        chk("hit_rdcyc", rd_cyc, 0);
        chk("hit_dout", dout_at_done, 13'h10F0);
        chk("hit_pulse", done_after, 1'b0);
        chk("hit_cnt", {hit_count, miss_count}, 16'h0101);

        // Write miss to same index, different tag, read+write both high
        run_req(13'h00D, 13'h0ABC, 1'b1, 1'b1, 1'b0, 13'h0);
        chk("wm_lat", lat, 4);
        chk("wm_wrcyc", wr_cyc, 2);
        chk("wm_rdcyc", rd_cyc, 0);
        chk("wm_both", both, 0);
        chk("wm_maddr", maddr, 13'h00D);
        chk("wm_mdin", mdin, 13'h0ABC);
        chk("wm_instr", minstr, 1'b0);
        chk("wm_memfall", mem_at_done, 1'b0);
        chk("wm_cnt", {hit_count, miss_count}, 16'h0101);
        run_req(13'h005, 13'h0, 1'b1, 1'b0, 1'b0, 13'h1FFF);
        chk("wm_rd_lat", lat, 2);
        chk("wm_rd_dout", dout_at_done, 13'h10F0);

        // Write hit updates the line and writes through
        run_req(13'h005, 13'h1234, 1'b0, 1'b1, 1'b1, 13'h0);
        chk("wh_lat", lat, 4);
        chk("wh_wrcyc", wr_cyc, 2);
        chk("wh_mdin", mdin, 13'h1234);
        chk("wh_instr", minstr, 1'b1);
        run_req(13'h005, 13'h0, 1'b1, 1'b0, 1'b0, 13'h1FFF);
        chk("wh_rd_lat", lat, 2);
        chk("wh_rd_dout", dout_at_done, 13'h1234);
        chk("wh_cnt", {hit_count, miss_count}, 16'h0301);

        // Flush then read misses
        flush = 1'b1; tick(); flush = 1'b0;
        run_req(13'h005, 13'h0, 1'b1, 1'b0, 1'b0, 13'h0777);
        chk("fl_lat", lat, 4);
        chk("fl_rdcyc", rd_cyc, 2);
        chk("fl_dout", dout_at_done, 13'h0777);
        chk("fl_cnt", {hit_count, miss_count}, 16'h0302);

        // Reset while in MISS_READ
        address = 13'h015; read = 1'b1;
        tick(); tick();
        chk("rs_memrd", mem_read, 1'b1);
        chk("rs_maddr", mem_address, 13'h015);
        reset = 1'b1; read = 1'b0;
        tick();
        reset = 1'b0;
        chk("rs_memrd_low", {mem_read, mem_write, Done}, 3'b000);
        chk("rs_cnt", {hit_count, miss_count}, 16'h0000);
        tick(); tick();
        chk("rs_nodone", Done, 1'b0);
        run_req(13'h005, 13'h0, 1'b1, 1'b0, 1'b0, 13'h0555);
        chk("rs_rd_lat", lat, 4);
        chk("rs_rd_dout", dout_at_done, 13'h0555);
        chk("rs_rd_cnt", {hit_count, miss_count}, 16'h0001);

        // Hit counter saturation
        for (int i = 0; i < 260; i++) begin
            run_req(13'h005, 13'h0, 1'b1, 1'b0, 1'b0, 13'h0);
        end
        chk("sat_lat", lat, 2);
        chk("sat_cnt", {hit_count, miss_count}, 16'hFF01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-through, no-write-allocate cache placed between the CPU Control/datapath and Main_Memory. It presents the same request/Done handshake to the CPU that Main_Memory does, so Control can talk to it without change. On the memory side it drives Main_Memory's ports and waits for its Done. Lines are one 13-bit word. The line index is the address modulo LINES, which is the same rule as the shared modulo function.

## Interface
- LINES, 8, number of cache lines; power of two; index width IDX_W = log2(LINES)
- ADDR_W, 13, address width; tag width = ADDR_W − IDX_W
- DATA_W, 13, data word width
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- address  in  ADDR_W  CPU request address
- dataIn  in  DATA_W  CPU write data
- read  in  1  CPU read request, level, held until Done
- write  in  1  CPU write request, level, held until Done
- instruction  in  1  request class flag, forwarded to memory
- flush  in  1  invalidate all lines; honoured only in IDLE
- dataOut  out  DATA_W  read data, valid while Done=1, held afterward
- Done  out  1  one-cycle completion pulse to CPU
- mem_address  out  ADDR_W  to Main_Memory
- mem_dataIn  out  DATA_W  write data to Main_Memory
- mem_dataOut  in  DATA_W  read data from Main_Memory
- mem_read  out  1  memory read request, held until mem_Done
- mem_write  out  1  memory write request, held until mem_Done
- mem_instruction  out  1  latched instruction flag
- mem_Done  in  1  memory completion pulse
- hit_count  out  8  saturating count of read hits
- miss_count  out  8  saturating count of read misses

## Operation
- Split: index = address[IDX_W-1:0]; tag = address[ADDR_W-1:IDX_W]. Each line holds a valid bit, a tag and a data word.
- **IDLE**
  - While Done=1 no request is accepted. This gives a one-cycle turnaround so a still-held request is not retaken.
  - If flush=1, all valid bits clear at the next edge and the state stays IDLE. Flush takes priority over read/write in the same cycle.
  - Otherwise, on read or write, latch address, dataIn, instruction and the operation, then go to LOOKUP.
  - If read and write are both high, the request is treated as a write.
- **LOOKUP**
  - Read hit: dataOut ← line data, Done ← 1, hit_count += 1, go to IDLE.
  - Read miss: miss_count += 1, go to MISS_READ.
  - Write, hit or miss: if hit, update the line data now (write-update). Then go to WRITE_THRU. A write miss does not allocate.
- **MISS_READ**
  - mem_read=1 and mem_address = latched address.
  - On mem_Done: fill the line (valid ← 1, tag, data ← mem_dataOut), dataOut ← mem_dataOut, Done ← 1, go to IDLE.
- **WRITE_THRU**
  - mem_write=1 with mem_address and mem_dataIn from the latches.
  - On mem_Done: Done ← 1, go to IDLE.
- Counters saturate at 8'hFF. Writes do not change either counter.
- mem_read and mem_write are never high together.
- mem_address, mem_dataIn and mem_instruction come from the latches and are stable for the whole request.

## Timing
- Reset values: state IDLE, all valid bits 0, dataOut 0, Done 0, mem_read/mem_write 0, mem_address/mem_dataIn/mem_instruction 0, counters 0.
- Reset during any state aborts the operation. mem_read and mem_write are low from the cycle after the reset edge, and no Done is issued.
- Read hit: request sampled at edge k; Done high in the cycle after edge k+1, so latency is 2 cycles.
- Read miss and write: mem request rises after edge k+1. Done rises on the edge that samples mem_Done=1. mem_read/mem_write fall on that same edge.
- Done is exactly one cycle wide.
- The CPU must drop read/write in the cycle Done is seen.
- mem_Done seen in IDLE or LOOKUP is ignored.

## Structure
- Package cache_pkg holds the state enum (IDLE, LOOKUP, MISS_READ, WRITE_THRU) and the ADDR_W, DATA_W and LINES defaults.
- Sub-module cache_line_store holds the valid/tag/data arrays.
  - One registered write port: fill or update.
  - Single-cycle flush clear.
  - Combinational read by index with a hit output.
- The FSM, latches and counters live in cache_controller.

## Test plan
- Cold read of 13'h005, memory returns 13'h10F0 → mem_read with mem_address=13'h005 until mem_Done; Done with dataOut=13'h10F0; miss_count=1.
- Repeat read of 13'h005 → Done exactly 2 cycles after the request; no mem_read; dataOut=13'h10F0; hit_count=1.
- Write 13'h0ABC to 13'h00D (index 5, tag 1, different tag) → mem_write with mem_dataIn=13'h0ABC; line 5 unchanged; then read 13'h005 hits with 13'h10F0.
- Write 13'h1234 to 13'h005 (hit) → write-through issued; a subsequent read of 13'h005 hits and returns 13'h1234.
- Flush in IDLE, then read 13'h005 → miss; mem_read issued; miss_count increments.
- Reset asserted while in MISS_READ → mem_read low the next cycle; no Done; a following read of 13'h005 misses.
